pong_pixel_pipeline: RTL and testbench

//  Parametrised, pipelined per-pixel colour generator for the Pong display path.

---
 rtl/pong_pixel_pipeline.sv | 195 +++++++++++++++++++
 tb/tb_pong_pixel_pipeline.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_pixel_pipeline.sv
// pong_pixel_pipeline: two-stage per-pixel colour generator for the Pong display.
// Draws two paddles and the ball from coordinates latched at each frame_start
// (tear-free), and runs a goal-flash sequencer that blinks the background.
// Optional build macro: PONG_BORDER_EN draws a one-pixel screen border.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   frame_start           1-cycle pulse at start of frame (latches shadows, steps flash)
//   pixel_valid_in/x/y    pixel request, one per cycle, no stall
//   ball_x/y, paddle_*_x  live object positions from game logic
//   goal_pulse            1-cycle pulse when a point is scored
//   pixel_valid_out/rgb   colour result, 2 cycles after the request
//   flash_active          high while the goal flash is running
module pong_pixel_pipeline #(
  parameter int unsigned       X_W            = 8,
  parameter int unsigned       Y_W            = 9,
  parameter int unsigned       RGB_W          = 16,
  parameter int unsigned       BALL_SIZE      = 10,
  parameter int unsigned       PADDLE_LEN     = 40,
  parameter int unsigned       PADDLE_THICK   = 5,
  parameter int unsigned       PADDLE_1_Y     = 30,
  parameter int unsigned       PADDLE_2_Y     = 290,
  parameter logic [RGB_W-1:0]  BACKGROUND_RGB = 16'h0000,
  parameter logic [RGB_W-1:0]  BALL_RGB       = 16'h07C0,
  parameter logic [RGB_W-1:0]  PADDLE_1_RGB   = 16'hF800,
  parameter logic [RGB_W-1:0]  PADDLE_2_RGB   = 16'h003F,
  parameter logic [RGB_W-1:0]  FLASH_RGB      = 16'hFFFF,
  parameter int unsigned       FLASH_FRAMES   = 30,
  parameter int unsigned       SCREEN_W       = 240,
  parameter int unsigned       SCREEN_H       = 320,
  parameter logic [RGB_W-1:0]  BORDER_RGB     = 16'hFFE0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             pixel_valid_in,
  input  logic [X_W-1:0]   pixel_x,
  input  logic [Y_W-1:0]   pixel_y,
  input  logic [X_W-1:0]   ball_x,
  input  logic [Y_W-1:0]   ball_y,
  input  logic [X_W-1:0]   paddle_1_x,
  input  logic [X_W-1:0]   paddle_2_x,
  input  logic             goal_pulse,
  output logic             pixel_valid_out,
  output logic [RGB_W-1:0] pixel_rgb,
  output logic             flash_active
);

  localparam int unsigned XE_W  = X_W + 1;
  localparam int unsigned YE_W  = Y_W + 1;
  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

`ifdef PONG_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLASH = 2'd2
  } flash_state_t;

  // Per-frame shadow copies of object positions
  logic [X_W-1:0] r_ball_x, r_p1_x, r_p2_x;
  logic [Y_W-1:0] r_ball_y;

  // Flash sequencer
  flash_state_t   r_state, w_state_next;
  logic [CNT_W-1:0] r_flash_cnt, w_cnt_next;
  logic           r_flash_active, w_active_next;

  // Pipeline registers
  logic             r_s1_valid, r_s1_p1, r_s1_p2, r_s1_ball, r_s1_border, r_s1_flash_bg;
  logic             r_s2_valid;
  logic [RGB_W-1:0] r_rgb;

  // Hit tests with one guard bit on the upper bound so edges near max never wrap
  logic [XE_W-1:0] w_px, w_ball_x_end, w_p1_x_end, w_p2_x_end;
  logic [YE_W-1:0] w_py, w_ball_y_end;
  logic            w_hit_ball, w_hit_p1, w_hit_p2, w_border, w_flash_bg;
  logic [RGB_W-1:0] w_colour;

  assign w_px         = {1'b0, pixel_x};
  assign w_py         = {1'b0, pixel_y};
  assign w_ball_x_end = {1'b0, r_ball_x} + XE_W'(BALL_SIZE);
  assign w_ball_y_end = {1'b0, r_ball_y} + YE_W'(BALL_SIZE);
  assign w_p1_x_end   = {1'b0, r_p1_x} + XE_W'(PADDLE_LEN);
  assign w_p2_x_end   = {1'b0, r_p2_x} + XE_W'(PADDLE_LEN);

  assign w_hit_ball = (pixel_x >= r_ball_x) && (w_px <= w_ball_x_end) &&
                      (pixel_y >= r_ball_y) && (w_py <= w_ball_y_end);
  assign w_hit_p1   = (pixel_x >= r_p1_x) && (w_px <= w_p1_x_end) &&
                      (w_py >= YE_W'(PADDLE_1_Y)) &&
                      (w_py <= YE_W'(PADDLE_1_Y + PADDLE_THICK));
  assign w_hit_p2   = (pixel_x >= r_p2_x) && (w_px <= w_p2_x_end) &&
                      (w_py >= YE_W'(PADDLE_2_Y)) &&
                      (w_py <= YE_W'(PADDLE_2_Y + PADDLE_THICK));
  assign w_border   = BORDER_ON &&
                      ((pixel_x == X_W'(0)) || (pixel_x == X_W'(SCREEN_W - 1)) ||
                       (pixel_y == Y_W'(0)) || (pixel_y == Y_W'(SCREEN_H - 1)));
  // Background flashes on even frames of the sequence
  assign w_flash_bg = r_flash_active && !r_flash_cnt[0];

  // Flash sequencer next state; flash_active only moves on frame_start
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_flash_cnt;
    w_active_next = r_flash_active;
    case (r_state)
      ST_IDLE: begin
        if (goal_pulse) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (frame_start) begin
          w_state_next = ST_FLASH;
          w_cnt_next   = '0;
        end
      end
      ST_FLASH: begin
        if (frame_start && goal_pulse) begin
          w_cnt_next = '0;  // restart lands directly on this boundary
        end else if (goal_pulse) begin
          w_state_next = ST_ARMED;
        end else if (frame_start) begin
          if (r_flash_cnt == CNT_LAST) w_state_next = ST_IDLE;
          else                         w_cnt_next   = r_flash_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (frame_start) w_active_next = (w_state_next == ST_FLASH);
  end

  // Flash sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_flash_cnt    <= '0;
      r_flash_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_flash_cnt    <= w_cnt_next;
      r_flash_active <= w_active_next;
    end
  end

  // Colour priority: paddle 2 > paddle 1 > ball > border > background
  always_comb begin
    w_colour = r_s1_flash_bg ? FLASH_RGB : BACKGROUND_RGB;
    if      (r_s1_p2)     w_colour = PADDLE_2_RGB;
    else if (r_s1_p1)     w_colour = PADDLE_1_RGB;
    else if (r_s1_ball)   w_colour = BALL_RGB;
    else if (r_s1_border) w_colour = BORDER_RGB;
  end

  // Shadow latch and two-stage pixel pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ball_x      <= '0;
      r_ball_y      <= '0;
      r_p1_x        <= '0;
      r_p2_x        <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_p1       <= 1'b0;
      r_s1_p2       <= 1'b0;
      r_s1_ball     <= 1'b0;
      r_s1_border   <= 1'b0;
      r_s1_flash_bg <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_rgb         <= BACKGROUND_RGB;
    end else begin
      if (frame_start) begin
        r_ball_x <= ball_x;
        r_ball_y <= ball_y;
        r_p1_x   <= paddle_1_x;
        r_p2_x   <= paddle_2_x;
      end
      r_s1_valid    <= pixel_valid_in;
      r_s1_p1       <= w_hit_p1;
      r_s1_p2       <= w_hit_p2;
      r_s1_ball     <= w_hit_ball;
      r_s1_border   <= w_border;
      r_s1_flash_bg <= w_flash_bg;
      r_s2_valid    <= r_s1_valid;
      if (r_s1_valid) r_rgb <= w_colour;
    end
  end

  assign pixel_valid_out = r_s2_valid;
  assign pixel_rgb       = r_rgb;
  assign flash_active    = r_flash_active;

endmodule

// File: tb/tb_pong_pixel_pipeline.sv
module tb_pong_pixel_pipeline;

  localparam int FF   = 4;
  localparam int BS   = 10;
  localparam int PL   = 40;
  localparam int PT   = 5;
  localparam int P1Y  = 30;
  localparam int P2Y  = 290;
  localparam int SW   = 240;
  localparam int SH   = 320;

  logic        clock = 1'b0;
  logic        reset, frame_start, pixel_valid_in, goal_pulse;
  logic [7:0]  pixel_x, ball_x, paddle_1_x, paddle_2_x;
  logic [8:0]  pixel_y, ball_y;
  logic        pixel_valid_out, flash_active;
  logic [15:0] pixel_rgb;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int sh_bx, sh_by, sh_p1, sh_p2;
  bit m_pend, m_active;
  int m_cnt;
  bit prev_v;
  logic [15:0] prev_c;
  bit exp_v;
  logic [15:0] exp_rgb;

  always #5 clock = ~clock;

  pong_pixel_pipeline #(.FLASH_FRAMES(FF)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .pixel_valid_in(pixel_valid_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_1_x(paddle_1_x),
    .paddle_2_x(paddle_2_x), .goal_pulse(goal_pulse),
    .pixel_valid_out(pixel_valid_out), .pixel_rgb(pixel_rgb),
    .flash_active(flash_active)
  );

  function automatic logic [15:0] ref_colour(int px, int py);
    bit border;
    if (px >= sh_p2 && px <= sh_p2 + PL && py >= P2Y && py <= P2Y + PT) return 16'h003F;
    if (px >= sh_p1 && px <= sh_p1 + PL && py >= P1Y && py <= P1Y + PT) return 16'hF800;
    if (px >= sh_bx && px <= sh_bx + BS && py >= sh_by && py <= sh_by + BS) return 16'h07C0;
`ifdef PONG_BORDER_EN
    border = (px == 0) || (px == SW - 1) || (py == 0) || (py == SH - 1);
`else
    border = 1'b0;
`endif
    if (border) return 16'hFFE0;
    return (m_active && (m_cnt % 2 == 0)) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance model, compare outputs
  task automatic tick();
    bit cur_v, f, g, r;
    logic [15:0] cur_c;
    int ibx, iby, ip1, ip2;
    cur_v = pixel_valid_in;
    cur_c = ref_colour(int'(pixel_x), int'(pixel_y));
    f = frame_start; g = goal_pulse; r = reset;
    ibx = int'(ball_x); iby = int'(ball_y); ip1 = int'(paddle_1_x); ip2 = int'(paddle_2_x);
    @(posedge clock);
    #1;
    if (r) begin
      sh_bx = 0; sh_by = 0; sh_p1 = 0; sh_p2 = 0;
      m_pend = 0; m_active = 0; m_cnt = 0;
      prev_v = 0; exp_v = 0; exp_rgb = 16'h0000;
    end else begin
      exp_v = prev_v;
      if (prev_v) exp_rgb = prev_c;
      prev_v = cur_v;
      prev_c = cur_c;
      if (f) begin
        sh_bx = ibx; sh_by = iby; sh_p1 = ip1; sh_p2 = ip2;
        if (m_pend) begin m_active = 1; m_cnt = 0; m_pend = 0; end
        else if (m_active && g) m_cnt = 0;
        else if (m_active) begin
          if (m_cnt == FF - 1) m_active = 0;
          else m_cnt++;
        end
        else if (g) m_pend = 1;
      end else if (g && !m_pend) begin
        m_pend = 1;
      end
    end
    chk("valid_out", 32'(pixel_valid_out), 32'(exp_v));
    chk("rgb", 32'(pixel_rgb), 32'(exp_rgb));
    chk("flash_active", 32'(flash_active), 32'(m_active));
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic goal();
    goal_pulse = 1'b1;
    tick();
    goal_pulse = 1'b0;
  endtask

  task automatic px_check(input int x, input int y, input logic [15:0] expc, input string tag);
    pixel_valid_in = 1'b1;
    pixel_x = 8'(x);
    pixel_y = 9'(y);
    tick();
    pixel_valid_in = 1'b0;
    tick();
    chk(tag, 32'(pixel_rgb), 32'(expc));
  endtask

  initial begin
    logic [15:0] border_exp;
    reset = 1'b1; frame_start = 1'b0; pixel_valid_in = 1'b0; goal_pulse = 1'b0;
    pixel_x = '0; pixel_y = '0; ball_x = 8'd200; ball_y = 9'd100;
    paddle_1_x = '0; paddle_2_x = '0;
    tick();
    tick();
    chk("reset_rgb", 32'(pixel_rgb), 32'h0000);
    chk("reset_valid", 32'(pixel_valid_out), 32'h0);
    reset = 1'b0;

    // Reset mid-stream with a valid pixel stream running
    pixel_valid_in = 1'b1; pixel_x = 8'd5; pixel_y = 9'd5;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_valid0", 32'(pixel_valid_out), 32'h0);
    chk("midrst_rgb0", 32'(pixel_rgb), 32'h0000);
    reset = 1'b0;
    tick();
    chk("midrst_valid1", 32'(pixel_valid_out), 32'h0);
    tick();
    chk("midrst_valid2", 32'(pixel_valid_out), 32'h1);
    pixel_valid_in = 1'b0;
    tick();

    // Shadowing: paddle 1 latched at 100, live input moved to 10 mid-frame
    paddle_1_x = 8'd100; paddle_2_x = 8'd0; ball_x = 8'd200; ball_y = 9'd150;
    fs_pulse();
    paddle_1_x = 8'd10;
    px_check(120, 32, 16'hF800, "shadow_p1_in");
    px_check(20, 32, 16'h0000, "shadow_p1_out");
    fs_pulse();
    px_check(20, 32, 16'hF800, "shadow_p1_new");

    // Overlap: paddle 2 beats ball
    paddle_2_x = 8'd50; ball_x = 8'd60; ball_y = 9'd288;
    fs_pulse();
    px_check(60, 290, 16'h003F, "overlap_p2");
    px_check(65, 289, 16'h07C0, "overlap_ball");

    // Wrap guard near max x
    ball_x = 8'd250; ball_y = 9'd150; paddle_2_x = 8'd0;
    fs_pulse();
    px_check(5, 150, 16'h0000, "wrap_low");
    px_check(255, 150, 16'h07C0, "wrap_high");
    px_check(250, 160, 16'h07C0, "ball_corner");
    px_check(250, 161, 16'h0000, "ball_below");

    // Goal flash sequence
    ball_x = 8'd200; ball_y = 9'd100;
    fs_pulse();
    goal();
    px_check(120, 150, 16'h0000, "armed_no_flash");
    fs_pulse();
    chk("flash_on", 32'(flash_active), 32'h1);
    px_check(120, 150, 16'hFFFF, "flash_f0");
    fs_pulse(); px_check(120, 150, 16'h0000, "flash_f1");
    fs_pulse(); px_check(120, 150, 16'hFFFF, "flash_f2");
    fs_pulse(); px_check(120, 150, 16'h0000, "flash_f3");
    fs_pulse(); px_check(120, 150, 16'h0000, "flash_done");
    chk("flash_off", 32'(flash_active), 32'h0);

    // Goal during flash restarts the sequence at the next frame
    goal();
    fs_pulse(); px_check(120, 150, 16'hFFFF, "rs_f0");
    fs_pulse(); px_check(120, 150, 16'h0000, "rs_f1");
    goal();     px_check(120, 150, 16'h0000, "rs_hold");
    fs_pulse(); px_check(120, 150, 16'hFFFF, "rs_restart");
    fs_pulse(); px_check(120, 150, 16'h0000, "rs_r1");
    fs_pulse(); px_check(120, 150, 16'hFFFF, "rs_r2");
    fs_pulse(); px_check(120, 150, 16'h0000, "rs_r3");
    fs_pulse();
    chk("rs_off", 32'(flash_active), 32'h0);

    // Goal and frame_start together while idle only arm
    goal_pulse = 1'b1; frame_start = 1'b1;
    tick();
    goal_pulse = 1'b0; frame_start = 1'b0;
    chk("idle_goal_fs", 32'(flash_active), 32'h0);
    fs_pulse();
    chk("idle_goal_fs_next", 32'(flash_active), 32'h1);
    for (int i = 0; i < FF; i++) fs_pulse();
    chk("idle_goal_fs_end", 32'(flash_active), 32'h0);

    // Border pixels
    paddle_1_x = 8'd100; paddle_2_x = 8'd100; ball_x = 8'd200; ball_y = 9'd200;
    fs_pulse();
`ifdef PONG_BORDER_EN
    border_exp = 16'hFFE0;
`else
    border_exp = 16'h0000;
`endif
    px_check(0, 100, border_exp, "border_left");
    px_check(239, 0, border_exp, "border_corner");
    px_check(120, 319, border_exp, "border_bottom");

    // Randomized frames with live inputs changing every cycle
    for (int fr = 0; fr < 30; fr++) begin
      ball_x = 8'($urandom_range(0, 255)); ball_y = 9'($urandom_range(0, 319));
      paddle_1_x = 8'($urandom_range(0, 255)); paddle_2_x = 8'($urandom_range(0, 255));
      goal_pulse = ($urandom_range(0, 7) == 0);
      pixel_valid_in = 1'b1;
      fs_pulse();
      goal_pulse = 1'b0;
      for (int c = 0; c < 40; c++) begin
        int mode;
        mode = int'($urandom_range(0, 3));
        pixel_valid_in = ($urandom_range(0, 3) != 0);
        goal_pulse = ($urandom_range(0, 63) == 0);
        ball_x = 8'($urandom_range(0, 255)); ball_y = 9'($urandom_range(0, 319));
        paddle_1_x = 8'($urandom_range(0, 255)); paddle_2_x = 8'($urandom_range(0, 255));
        case (mode)
          0: begin
            pixel_x = 8'($urandom_range(0, 255)); pixel_y = 9'($urandom_range(0, 319));
          end
          1: begin
            pixel_x = 8'(sh_bx + int'($urandom_range(0, 14)) - 2);
            pixel_y = 9'(sh_by + int'($urandom_range(0, 14)) - 2);
          end
          2: begin
            pixel_x = 8'(sh_p1 + int'($urandom_range(0, 46)) - 3);
            pixel_y = 9'(P1Y + int'($urandom_range(0, 9)) - 2);
          end
          default: begin
            pixel_x = 8'(sh_p2 + int'($urandom_range(0, 46)) - 3);
            pixel_y = 9'(P2Y + int'($urandom_range(0, 9)) - 2);
          end
        endcase
        tick();
      end
      goal_pulse = 1'b0;
    end
    pixel_valid_in = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
